// File: rtl/fp_normround.sv
// rtl/fp_normround.sv - post-adder normalize and round-to-nearest-even stage, two registered stages
module fp_normround #(
    parameter int LOG_BIT = 5,
    parameter int EXP_BIT = 8,
    parameter int N_BIT   = 1 << LOG_BIT,
    parameter int MAN_BIT = N_BIT - EXP_BIT - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_BIT-1:0] in_exp,
    input  logic [MAN_BIT+1:0] in_man,
    input  logic               in_guard,
    input  logic               in_sticky,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BIT-1:0]   out
);
    localparam int LZ_W = $clog2(MAN_BIT + 2);
    localparam logic [EXP_BIT-1:0] EXP_ONES = '1;
    localparam logic [EXP_BIT:0]   EXP_ONE  = (EXP_BIT+1)'(1);

    logic               s1_valid;
    logic               s1_sign;
    logic               s1_special;
    logic               s1_guard;
    logic               s1_sticky;
    logic [EXP_BIT:0]   s1_exp;
    logic [MAN_BIT:0]   s1_man;
    logic               s2_valid;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Leading zeros counted down from the hidden-bit position; the highest set bit wins.
    logic [LZ_W-1:0] lz;
    always_comb begin
        lz = LZ_W'(MAN_BIT + 1);
        for (int i = 0; i <= MAN_BIT; i++) begin
            if (in_man[i]) lz = LZ_W'(MAN_BIT - i);
        end
    end

    logic               n_special;
    logic               n_guard;
    logic               n_sticky;
    logic [EXP_BIT:0]   n_exp;
    logic [MAN_BIT:0]   n_man;
    logic [EXP_BIT:0]   lz_e;
    logic [EXP_BIT:0]   exp_m1;
    logic [EXP_BIT:0]   shift;
    logic [MAN_BIT+1:0] shifted;

    assign lz_e   = (EXP_BIT+1)'(lz);
    assign exp_m1 = {1'b0, in_exp} - EXP_ONE;

    always_comb begin
        n_special = 1'b0;
        n_exp     = {1'b0, in_exp};
        n_man     = in_man[MAN_BIT:0];
        n_guard   = in_guard;
        n_sticky  = in_sticky;
        shift     = '0;
        shifted   = '0;
        if (in_exp == EXP_ONES) begin
            n_special = 1'b1;
        end else if (in_man[MAN_BIT+1]) begin
            n_man    = in_man[MAN_BIT+1:1];
            n_exp    = {1'b0, in_exp} + EXP_ONE;
            n_guard  = in_man[0];
            n_sticky = in_guard | in_sticky;
        end else if (in_man == '0 && !in_guard && !in_sticky) begin
            n_exp = '0;
        end else begin
            // Shift is capped so the exponent never drops below 1; guard feeds the first vacated bit.
            if (in_exp != '0) shift = (lz_e < exp_m1) ? lz_e : exp_m1;
            shifted = {in_man[MAN_BIT:0], in_guard} << shift;
            n_man   = shifted[MAN_BIT+1:1];
            n_guard = shifted[0];
            n_exp   = {1'b0, in_exp} - shift;
            if (!n_man[MAN_BIT]) n_exp = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_special <= n_special;
                s1_exp     <= n_exp;
                s1_man     <= n_man;
                s1_guard   <= n_guard;
                s1_sticky  <= n_sticky;
            end
        end
    end

    logic               round_up;
    logic [MAN_BIT+1:0] sum;
    logic [EXP_BIT:0]   r_exp;
    logic [N_BIT-1:0]   packed_word;

    always_comb begin
        round_up    = s1_guard & (s1_sticky | s1_man[0]);
        sum         = {1'b0, s1_man} + (MAN_BIT+2)'(round_up);
        r_exp       = s1_exp;
        packed_word = '0;
        if (s1_special) begin
            packed_word = {s1_sign, EXP_ONES, s1_man[MAN_BIT-1:0]};
        end else begin
            // A carry out of the hidden bit leaves the fraction field all-zero.
            if (sum[MAN_BIT+1]) r_exp = s1_exp + EXP_ONE;
            else if (s1_exp == '0 && sum[MAN_BIT]) r_exp = EXP_ONE;
            if (r_exp >= {1'b0, EXP_ONES}) packed_word = {s1_sign, EXP_ONES, {MAN_BIT{1'b0}}};
            else packed_word = {s1_sign, r_exp[EXP_BIT-1:0], sum[MAN_BIT-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out      <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) out <= packed_word;
        end
    end
endmodule

// File: tb/tb_fp_normround.sv
// tb/tb_fp_normround.sv - self-checking bench for fp_normround against a behavioural model
module tb_fp_normround;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_man = '0;
    logic        in_guard = 1'b0;
    logic        in_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    fp_normround dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .in_guard(in_guard), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    // Value-level model: walk the significand one bit at a time, then round with integer arithmetic.
    function automatic logic [31:0] ref_model(input logic sg, input logic [7:0] e_in,
                                              input logic [24:0] man, input logic g, input logic s);
        longint m;
        int e;
        logic gg;
        logic ss;
        m = man;
        e = e_in;
        gg = g;
        ss = s;
        if (e_in == 8'hFF) return {sg, 8'hFF, man[22:0]};
        if (m >= (64'sd1 << 24)) begin
            ss = gg | ss;
            gg = man[0];
            m = m / 2;
            e = e + 1;
        end else if (m == 0 && !g && !s) begin
            return {sg, 31'd0};
        end else if (e != 0) begin
            while (e > 1 && m < (64'sd1 << 23)) begin
                m = m * 2 + longint'(gg);
                gg = 1'b0;
                e = e - 1;
            end
        end
        if (m < (64'sd1 << 23)) e = 0;
        if (gg && (ss || (m % 2 == 1))) m = m + 1;
        if (m >= (64'sd1 << 24)) begin
            e = e + 1;
            m = 0;
        end else if (e == 0 && m >= (64'sd1 << 23)) begin
            e = 1;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        return {sg, e[7:0], m[22:0]};
    endfunction

    task automatic set_random_beat();
        logic [24:0] r;
        int sel;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0:       in_exp = 8'd0;
            1:       in_exp = 8'($urandom_range(1, 4));
            2:       in_exp = 8'd254;
            3:       in_exp = 8'd255;
            default: in_exp = 8'($urandom_range(1, 254));
        endcase
        r = 25'($urandom);
        in_man = r >> $urandom_range(0, 25);
        in_sign = 1'($urandom);
        in_guard = 1'($urandom);
        in_sticky = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h want=00000000", out); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_check(input string name, input logic sg, input logic [7:0] e,
                              input logic [24:0] m, input logic g, input logic s, input logic [31:0] want);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_sign = sg;
        in_exp = e;
        in_man = m;
        in_guard = g;
        in_sticky = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL %s_latency got=%0d want=2", name, lat); end
        checks++;
        if (out !== want) begin failures++; $display("FAIL %s got=%h want=%h", name, out, want); end
    endtask

    task automatic test_directed();
        send_check("carry",      1'b0, 8'd127, {2'b10, 23'h0},      1'b0, 1'b0, 32'h40000000);
        send_check("cancel",     1'b0, 8'd130, {2'b00, 23'h000400}, 1'b0, 1'b0, 32'h3A800000);
        send_check("denorm_cap", 1'b0, 8'd3,   {2'b00, 23'h000001}, 1'b0, 1'b0, 32'h00000004);
        send_check("denorm_e0",  1'b0, 8'd0,   25'd5,               1'b0, 1'b0, 32'h00000005);
        send_check("rne_tie_ev", 1'b0, 8'd127, {2'b01, 23'h0},      1'b1, 1'b0, 32'h3F800000);
        send_check("rne_tie_od", 1'b0, 8'd127, {2'b01, 23'h1},      1'b1, 1'b0, 32'h3F800002);
        send_check("rne_above",  1'b0, 8'd127, {2'b01, 23'h0},      1'b1, 1'b1, 32'h3F800001);
        send_check("overflow",   1'b0, 8'd254, {2'b01, 23'h7FFFFF}, 1'b1, 1'b1, 32'h7F800000);
        send_check("nan_pass",   1'b0, 8'd255, {2'b00, 23'h400000}, 1'b0, 1'b0, 32'h7FC00000);
        send_check("neg_zero",   1'b1, 8'd100, 25'd0,               1'b0, 1'b0, 32'h80000000);
    endtask

    // Streams n random beats; rdy_pct sets out_ready odds, stall3 forces it low for the first 3 cycles.
    task automatic run_stream(input string name, input int n, input int rdy_pct, input bit stall3,
                              output int cycles);
        int sent;
        int cyc;
        bit take;
        bit held_v;
        logic [31:0] held;
        logic [31:0] want;
        sent = 0;
        cyc = 0;
        take = 1'b0;
        held_v = 1'b0;
        held = '0;
        in_valid = 1'b0;
        while ((sent < n || exp_q.size() != 0) && cyc < 40 * n + 50) begin
            @(posedge clk); #1;
            if (take || !in_valid) begin
                if (sent < n) begin
                    in_valid = 1'b1;
                    set_random_beat();
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = stall3 ? (cyc >= 3) : (int'($urandom_range(0, 99)) < rdy_pct);
            @(negedge clk);
            take = in_valid && in_ready;
            if (stall3 && cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_in_ready_full got=%b want=0", name, in_ready); end
            end
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out !== held) begin
                    failures++;
                    $display("FAIL %s_hold got=%b/%h want=1/%h", name, out_valid, out, held);
                end
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s_extra got=%h want=no beat", name, out);
                    end else begin
                        want = exp_q.pop_front();
                        if (out !== want) begin failures++; $display("FAIL %s_data got=%h want=%h", name, out, want); end
                    end
                end else begin
                    held_v = 1'b1;
                    held = out;
                end
            end
            if (take) begin
                exp_q.push_back(ref_model(in_sign, in_exp, in_man, in_guard, in_sticky));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != n || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_complete got=sent %0d pending %0d want=sent %0d pending 0", name, sent, exp_q.size(), n);
        end
        exp_q.delete();
        cycles = cyc;
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_stream("b2b", 20, 100, 1'b0, cyc);
        checks++;
        if (cyc != 22) begin failures++; $display("FAIL b2b_throughput got=%0d want=22", cyc); end
    endtask

    task automatic test_random();
        int cyc;
        run_stream("rand", 300, 60, 1'b0, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        run_stream("bp", 4, 0, 1'b1, cyc);
    endtask

    task automatic test_reset_midflight();
        int stale;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_random_beat();
        @(posedge clk); #1;
        set_random_beat();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL midreset_stale got=%0d want=0", stale); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
